// File: rtl/vm_coin_conditioner_if.sv
// Coin-conditioner bus: raw sensor/control inputs in, clean accept pulses and total out.
interface vm_coin_conditioner_if #(
  parameter int TOT_W = 8
);
  logic [1:0]       Coin_raw;
  logic             Busy;
  logic             Clr_total;
  logic [1:0]       D_in;
  logic             Reject;
  logic [TOT_W-1:0] Total;

  modport master (output Coin_raw, Busy, Clr_total, input  D_in, Reject, Total);
  modport slave  (input  Coin_raw, Busy, Clr_total, output D_in, Reject, Total);
endinterface

// File: rtl/vm_coin_conditioner.sv
// Coin front end: per-line sync + debounce + rise detect, busy rejection,
// and a saturating total of accepted value in 0.5-unit steps.
module vm_coin_line #(
  parameter int DB_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw_i,
  output logic rise_o
);
  logic [1:0] sync_q;
  logic [3:0] cnt_q, cnt_d;
  logic       stb_q, stb_d;

  always_comb begin
    cnt_d = cnt_q;
    stb_d = stb_q;
    if (sync_q[1] == stb_q) begin
      cnt_d = '0;
    end else if (cnt_q == 4'(DB_CYCLES - 1)) begin
      stb_d = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      stb_q  <= stb_d;
    end
  end

  // Rise is taken from next-state so the output register lands on the same edge as stb.
  assign rise_o = stb_d & ~stb_q;
endmodule

module vm_coin_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int TOT_W     = 8,
  parameter int NUM_LANES = 2
) (
  input logic                   Clk,
  input logic                   Reset,
  vm_coin_conditioner_if.slave  io
);
  logic [NUM_LANES-1:0] rise;
  logic [1:0]           d_in_q, d_in_d;
  logic                 reject_q, reject_d;
  logic [TOT_W-1:0]     total_q, total_d;
  logic [TOT_W+1:0]     sum;

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_line
    vm_coin_line #(.DB_CYCLES(DB_CYCLES)) u_line (
      .Clk    (Clk),
      .Reset  (Reset),
      .raw_i  (io.Coin_raw[b]),
      .rise_o (rise[b])
    );
  end

  assign sum = (TOT_W+2)'(total_q) + (TOT_W+2)'(d_in_q[0]) + (TOT_W+2)'({d_in_q[1], 1'b0});

  always_comb begin
    d_in_d   = io.Busy ? 2'b00 : rise;
    reject_d = io.Busy & (|rise);
    total_d  = total_q;
    // Clear wins over a same-cycle add; that add is dropped.
    if (io.Clr_total)
      total_d = '0;
    else if (sum > (TOT_W+2)'({TOT_W{1'b1}}))
      total_d = {TOT_W{1'b1}};
    else
      total_d = sum[TOT_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      d_in_q   <= '0;
      reject_q <= 1'b0;
      total_q  <= '0;
    end else begin
      d_in_q   <= d_in_d;
      reject_q <= reject_d;
      total_q  <= total_d;
    end
  end

  assign io.D_in   = d_in_q;
  assign io.Reject = reject_q;
  assign io.Total  = total_q;
endmodule

// File: tb/tb_vm_coin_conditioner.sv
// Directed bench for vm_coin_conditioner (DB_CYCLES=4, TOT_W=8).
module tb_vm_coin_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   exp_tot = 0;

  vm_coin_conditioner_if #(.TOT_W(8)) bus ();

  vm_coin_conditioner #(.DB_CYCLES(4), .TOT_W(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coin held long enough to accept, then released long enough for stb to fall.
  task automatic insert(input logic [1:0] c);
    bus.Coin_raw = c;
    repeat (7) tick();
    bus.Coin_raw = 2'b00;
    repeat (7) tick();
  endtask

  task automatic test_reset();
    bus.Coin_raw = 2'b11; bus.Busy = 1'b0; bus.Clr_total = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    vecs++; if (bus.D_in !== 2'b00) begin errs++; $display("FAIL reset D_in got %b want 00", bus.D_in); end
    vecs++; if (bus.Reject !== 1'b0) begin errs++; $display("FAIL reset Reject got %b want 0", bus.Reject); end
    vecs++; if (bus.Total !== 8'd0) begin errs++; $display("FAIL reset Total got %0d want 0", bus.Total); end
    bus.Coin_raw = 2'b00;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    exp_tot = 0;
  endtask

  // Coin applied after edge e: first sample at e+1, stb/D_in at e+6 (loop i==5), Total at e+7.
  task automatic test_single();
    logic [1:0] e;
    bus.Coin_raw = 2'b01;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = (i == 5) ? 2'b01 : 2'b00;
      vecs++; if (bus.D_in !== e) begin errs++; $display("FAIL single D_in cyc %0d got %b want %b", i, bus.D_in, e); end
      if (i == 6) begin
        exp_tot = 1;
        vecs++; if (bus.Total !== 8'(exp_tot)) begin errs++; $display("FAIL single Total got %0d want %0d", bus.Total, exp_tot); end
      end
    end
    bus.Coin_raw = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++; if (bus.D_in !== 2'b00) begin errs++; $display("FAIL release D_in cyc %0d got %b want 00", i, bus.D_in); end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] e;
    bus.Coin_raw = 2'b10;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) bus.Coin_raw = 2'b00;
      tick();
      vecs++; if (bus.D_in !== 2'b00 || bus.Reject !== 1'b0) begin
        errs++; $display("FAIL short_pulse cyc %0d got D_in=%b Rej=%b want 00/0", i, bus.D_in, bus.Reject);
      end
    end
    vecs++; if (bus.Total !== 8'(exp_tot)) begin errs++; $display("FAIL short_pulse Total got %0d want %0d", bus.Total, exp_tot); end
    // Bounce 1,0,1,1,1,... : the steady run starts at i=2, so the pulse lands at i=7.
    for (int i = 0; i < 16; i++) begin
      bus.Coin_raw = (i == 1) ? 2'b00 : 2'b10;
      tick();
      e = (i == 7) ? 2'b10 : 2'b00;
      vecs++; if (bus.D_in !== e) begin errs++; $display("FAIL bounce D_in cyc %0d got %b want %b", i, bus.D_in, e); end
      if (i == 8) begin
        exp_tot += 2;
        vecs++; if (bus.Total !== 8'(exp_tot)) begin errs++; $display("FAIL bounce Total got %0d want %0d", bus.Total, exp_tot); end
      end
    end
    bus.Coin_raw = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_both();
    logic [1:0] e;
    bus.Coin_raw = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = (i == 5) ? 2'b11 : 2'b00;
      vecs++; if (bus.D_in !== e) begin errs++; $display("FAIL both D_in cyc %0d got %b want %b", i, bus.D_in, e); end
    end
    exp_tot += 3;
    vecs++; if (bus.Total !== 8'(exp_tot)) begin errs++; $display("FAIL both Total got %0d want %0d", bus.Total, exp_tot); end
    bus.Coin_raw = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_busy();
    logic r;
    bus.Busy = 1'b1;
    bus.Coin_raw = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick();
      r = (i == 5);
      vecs++; if (bus.D_in !== 2'b00 || bus.Reject !== r) begin
        errs++; $display("FAIL busy cyc %0d got D_in=%b Rej=%b want 00/%b", i, bus.D_in, bus.Reject, r);
      end
    end
    vecs++; if (bus.Total !== 8'(exp_tot)) begin errs++; $display("FAIL busy Total got %0d want %0d", bus.Total, exp_tot); end
    bus.Coin_raw = 2'b00;
    repeat (10) tick();
    bus.Busy = 1'b0;
    insert(2'b10);
    exp_tot += 2;
    vecs++; if (bus.Total !== 8'(exp_tot)) begin errs++; $display("FAIL unbusy Total got %0d want %0d", bus.Total, exp_tot); end
  endtask

  task automatic test_saturate();
    bus.Clr_total = 1'b1;
    tick();
    bus.Clr_total = 1'b0;
    vecs++; if (bus.Total !== 8'd0) begin errs++; $display("FAIL clr Total got %0d want 0", bus.Total); end
    repeat (86) insert(2'b10);
    vecs++; if (bus.Total !== 8'd172) begin errs++; $display("FAIL preload Total got %0d want 172", bus.Total); end
    repeat (41) insert(2'b10);
    vecs++; if (bus.Total !== 8'd254) begin errs++; $display("FAIL near_max Total got %0d want 254", bus.Total); end
    insert(2'b01);
    vecs++; if (bus.Total !== 8'd255) begin errs++; $display("FAIL at_max Total got %0d want 255", bus.Total); end
    insert(2'b10);
    vecs++; if (bus.Total !== 8'd255) begin errs++; $display("FAIL sat_hold Total got %0d want 255", bus.Total); end
    // Clear raised during the D_in pulse cycle, colliding with that pulse's add.
    bus.Coin_raw = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.Clr_total = (i == 5);
      if (i == 6) begin
        vecs++; if (bus.Total !== 8'd0) begin errs++; $display("FAIL clr_prio Total got %0d want 0", bus.Total); end
      end
    end
    vecs++; if (bus.Total !== 8'd0) begin errs++; $display("FAIL clr_after Total got %0d want 0", bus.Total); end
    bus.Coin_raw = 2'b00;
    repeat (10) tick();
    exp_tot = 0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] e;
    insert(2'b10);
    bus.Coin_raw = 2'b01;
    repeat (4) tick();   // cnt now 2
    rst = 1'b1;
    #1;
    vecs++; if (bus.D_in !== 2'b00 || bus.Total !== 8'd0) begin
      errs++; $display("FAIL mid_reset async got D_in=%b Total=%0d want 00/0", bus.D_in, bus.Total);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (bus.D_in !== 2'b00 || bus.Reject !== 1'b0 || bus.Total !== 8'd0) begin
        errs++; $display("FAIL mid_reset hold cyc %0d got D_in=%b Rej=%b Total=%0d", i, bus.D_in, bus.Reject, bus.Total);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = (i == 5) ? 2'b01 : 2'b00;
      vecs++; if (bus.D_in !== e) begin errs++; $display("FAIL post_reset D_in cyc %0d got %b want %b", i, bus.D_in, e); end
    end
    vecs++; if (bus.Total !== 8'd1) begin errs++; $display("FAIL post_reset Total got %0d want 1", bus.Total); end
    bus.Coin_raw = 2'b00;
    repeat (5) tick();
  endtask

  initial begin
    bus.Coin_raw = 2'b00; bus.Busy = 1'b0; bus.Clr_total = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_both();
    test_busy();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
